// File: rtl/div32x32.sv
// div32x32 - sequential radix-2 restoring divider with valid/ready on both sides.
//
// One quotient bit is resolved per clock, so every division takes the same
// number of cycles regardless of operand values.
//   accept edge -> WIDTH CALC edges -> one FIX edge -> result held in DONE
//
// Ports:
//   i_clk, i_rstn         clock (rising edge), asynchronous active-low reset
//   i_valid / o_ready     request handshake; o_ready is high only while idle
//   i_div_ns              1 = operands are two's-complement signed, 0 = unsigned
//   i_dividend, i_divisor operands, sampled only on the accept edge
//   o_valid / i_ready     result handshake; results are held while i_ready is low
//   o_quot, o_rem         quotient / remainder (truncating, rem takes dividend sign)
//   o_div0                divisor was zero for the presented result
module div32x32 #(
    parameter int WIDTH = 32
) (
    input  logic             i_clk,
    input  logic             i_rstn,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic             i_div_ns,
    input  logic [WIDTH-1:0] i_dividend,
    input  logic [WIDTH-1:0] i_divisor,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [WIDTH-1:0] o_quot,
    output logic [WIDTH-1:0] o_rem,
    output logic             o_div0
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] ONE     = {{(WIDTH-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;

    state_t           state, state_nxt;
    logic [CW-1:0]    cnt;
    logic             ns_q, qsgn_q, rsgn_q;
    logic [WIDTH-1:0] dvd_q;              // original dividend, needed for the div-by-zero result
    logic [WIDTH-1:0] dvs_q;              // divisor magnitude
    logic [WIDTH-1:0] quot_q, rem_q;      // shifting {rem,quot} pair

    logic             acc;
    logic             dvd_neg, dvs_neg;
    logic [WIDTH:0]   rem_sh, trial;
    logic [WIDTH-1:0] res_quot, res_rem;
    logic             res_div0, ovf;

    function automatic logic [WIDTH-1:0] neg(input logic [WIDTH-1:0] x);
        return ~x + ONE;
    endfunction

    assign acc     = i_valid & o_ready;
    assign dvd_neg = i_div_ns & i_dividend[WIDTH-1];
    assign dvs_neg = i_div_ns & i_divisor[WIDTH-1];

    // ---------------- state register ----------------
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state   <= S_IDLE;
            o_ready <= 1'b1;
        end else begin
            state   <= state_nxt;
            o_ready <= (state_nxt == S_IDLE);
        end
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (acc)          state_nxt = S_CALC;
            S_CALC: if (cnt == '0)    state_nxt = S_FIX;
            S_FIX:                    state_nxt = S_DONE;
            S_DONE: if (i_ready)      state_nxt = S_IDLE;
            default:                  state_nxt = S_IDLE;
        endcase
    end

    // ---------------- output / datapath combinational ----------------
    always_comb begin
        // Restoring step: partial remainder gets one extra bit so the trial
        // subtraction's borrow shows up as the MSB.
        rem_sh = {rem_q, quot_q[WIDTH-1]};
        trial  = rem_sh - {1'b0, dvs_q};

        // Most-negative / -1 is the only signed quotient that does not fit;
        // the divisor sign is recovered as qsgn ^ rsgn.
        ovf = ns_q && (dvd_q == MIN_NEG) && (dvs_q == ONE) && (qsgn_q != rsgn_q);

        res_div0 = 1'b0;
        res_quot = qsgn_q ? neg(quot_q) : quot_q;
        res_rem  = rsgn_q ? neg(rem_q)  : rem_q;
        if (dvs_q == '0) begin
            res_div0 = 1'b1;
            res_quot = '1;
            res_rem  = dvd_q;
        end else if (ovf) begin
            res_quot = MIN_NEG;
            res_rem  = '0;
        end
    end

    // ---------------- datapath / result registers ----------------
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            cnt     <= '0;
            ns_q    <= 1'b0;
            qsgn_q  <= 1'b0;
            rsgn_q  <= 1'b0;
            dvd_q   <= '0;
            dvs_q   <= '0;
            quot_q  <= '0;
            rem_q   <= '0;
            o_valid <= 1'b0;
            o_quot  <= '0;
            o_rem   <= '0;
            o_div0  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: if (acc) begin
                    ns_q   <= i_div_ns;
                    qsgn_q <= dvd_neg ^ dvs_neg;
                    rsgn_q <= dvd_neg;
                    dvd_q  <= i_dividend;
                    dvs_q  <= dvs_neg ? neg(i_divisor) : i_divisor;
                    quot_q <= dvd_neg ? neg(i_dividend) : i_dividend;
                    rem_q  <= '0;
                    cnt    <= CW'(WIDTH-1);
                end
                S_CALC: begin
                    if (!trial[WIDTH]) begin
                        rem_q  <= trial[WIDTH-1:0];
                        quot_q <= {quot_q[WIDTH-2:0], 1'b1};
                    end else begin
                        rem_q  <= rem_sh[WIDTH-1:0];
                        quot_q <= {quot_q[WIDTH-2:0], 1'b0};
                    end
                    cnt <= cnt - 1'b1;
                end
                S_FIX: begin
                    o_quot  <= res_quot;
                    o_rem   <= res_rem;
                    o_div0  <= res_div0;
                    o_valid <= 1'b1;
                end
                S_DONE: if (i_ready) o_valid <= 1'b0;
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_div32x32.sv
// Randomized + directed bench for div32x32; results compared with a plain
// arithmetic reference model.
module tb_div32x32;
    logic        clk = 1'b0;
    logic        rstn;
    logic        i_valid, i_div_ns, i_ready;
    logic [31:0] i_dividend, i_divisor;
    logic        o_ready, o_valid, o_div0;
    logic [31:0] o_quot, o_rem;

    int vecs = 0;
    int errs = 0;

    always #5 clk = ~clk;

    div32x32 #(.WIDTH(32)) dut (
        .i_clk(clk), .i_rstn(rstn),
        .i_valid(i_valid), .o_ready(o_ready), .i_div_ns(i_div_ns),
        .i_dividend(i_dividend), .i_divisor(i_divisor),
        .o_valid(o_valid), .i_ready(i_ready),
        .o_quot(o_quot), .o_rem(o_rem), .o_div0(o_div0)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vecs++;
        if (obs !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference: divide-by-zero convention first, then ordinary truncating
    // division in 64-bit arithmetic (which also covers MIN/-1 naturally).
    task automatic model(input bit ns, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] q, output logic [31:0] r, output logic d0);
        longint sa, sb;
        d0 = 1'b0;
        if (b == 0) begin
            q = 32'hFFFF_FFFF; r = a; d0 = 1'b1;
        end else if (ns) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            q  = 32'(sa / sb);
            r  = 32'(sa % sb);
        end else begin
            q = a / b;
            r = a % b;
        end
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 6))
            0:       return 32'h0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'($urandom_range(1, 20));
            4:       return 32'h0 - 32'($urandom_range(1, 20));
            default: return $urandom;
        endcase
    endfunction

    task automatic scramble();
        i_valid    = 1'($urandom_range(0, 1));
        i_div_ns   = 1'($urandom_range(0, 1));
        i_dividend = $urandom;
        i_divisor  = $urandom;
    endtask

    // Called at a negedge with i_valid low. Issues one request, checks latency,
    // result, stability under backpressure for `hold` cycles, and release.
    task automatic run_div(input bit ns, input logic [31:0] a, input logic [31:0] b, input int hold);
        logic [31:0] eq, er;
        logic        ed;
        int          edges;
        model(ns, a, b, eq, er, ed);
        edges = 0;
        while (!o_ready && edges < 50) begin
            @(negedge clk); edges++;
        end
        chk("idle_ready", {31'b0, o_ready}, 32'd1);
        i_valid = 1'b1; i_div_ns = ns; i_dividend = a; i_divisor = b;
        @(posedge clk);                     // accept edge
        edges = 0;
        do begin
            @(posedge clk); edges++;
            @(negedge clk);
            scramble();                     // must be ignored while busy
        end while (!o_valid && edges < 100);
        chk("latency", edges, 32'd33);
        chk("quot", o_quot, eq);
        chk("rem", o_rem, er);
        chk("div0", {31'b0, o_div0}, {31'b0, ed});
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); @(negedge clk);
            scramble();
            chk("hold_quot", o_quot, eq);
            chk("hold_rem", o_rem, er);
            chk("hold_vr", {30'b0, o_valid, o_ready}, 32'b10);
        end
        i_ready = 1'b1; i_valid = 1'b0;
        @(posedge clk); @(negedge clk);
        chk("release_vr", {30'b0, o_valid, o_ready}, 32'b01);
        chk("retain_quot", o_quot, eq);
        i_ready = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        rstn = 1'b0; i_valid = 1'b0; i_div_ns = 1'b0; i_ready = 1'b0;
        i_dividend = '0; i_divisor = '0;
        repeat (3) @(negedge clk);
        chk("rst_ready", {31'b0, o_ready}, 32'd1);
        chk("rst_valid", {31'b0, o_valid}, 32'd0);
        chk("rst_quot", o_quot, 32'd0);
        chk("rst_rem", o_rem, 32'd0);
        chk("rst_div0", {31'b0, o_div0}, 32'd0);
        rstn = 1'b1;
        @(negedge clk);

        // directed corner cases
        run_div(1'b0, 32'd100,        32'd7,        0);
        chk("const_100_7", o_rem, 32'd2);
        run_div(1'b1, 32'hFFFF_FF9C,  32'd7,        1);
        run_div(1'b1, 32'd100,        32'hFFFF_FFF9, 0);
        run_div(1'b0, 32'h1234_5678,  32'd0,        2);
        run_div(1'b1, 32'h1234_5678,  32'd0,        0);
        run_div(1'b1, 32'h8000_0000,  32'hFFFF_FFFF, 0);
        chk("const_ovf_q", o_quot, 32'h8000_0000);
        run_div(1'b0, 32'hFFFF_FFFF,  32'd1,        0);
        run_div(1'b0, 32'h8000_0000,  32'hFFFF_FFFF, 0);
        run_div(1'b1, 32'h8000_0000,  32'd0,        0);
        run_div(1'b0, 32'd100,        32'd7,        5);

        // randomized
        for (int n = 0; n < 40; n++)
            run_div(1'($urandom_range(0, 1)), pick(), pick(), $urandom_range(0, 3));

        // reset in the middle of a calculation
        i_valid = 1'b1; i_div_ns = 1'b0; i_dividend = 32'd1234; i_divisor = 32'd5;
        @(posedge clk);
        @(negedge clk); i_valid = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        rstn = 1'b0;
        #1;
        chk("abort_valid", {31'b0, o_valid}, 32'd0);
        chk("abort_ready", {31'b0, o_ready}, 32'd1);
        chk("abort_quot", o_quot, 32'd0);
        chk("abort_rem", o_rem, 32'd0);
        chk("abort_div0", {31'b0, o_div0}, 32'd0);
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        repeat (40) begin
            @(negedge clk);
            if (o_valid) chk("abort_no_result", {31'b0, o_valid}, 32'd0);
        end
        chk("post_rst_ready", {31'b0, o_ready}, 32'd1);
        run_div(1'b0, 32'd7, 32'd7, 0);
        chk("const_7_7", o_quot, 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
